// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin packet arbiter for a shared FIFO write port
// Optional per-requester accepted-beat counters: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_data_in,
  input  logic                      fifo_full,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NUM_REQ*CNT_W-1:0]  stat_cnt
`endif
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_owner;

  state_t          w_state_nxt;
  logic [ID_W-1:0] w_rr_ptr_nxt;
  logic [ID_W-1:0] w_owner_nxt;

  logic            w_found;
  logic [ID_W-1:0] w_winner;
  logic            w_sel_valid;
  logic [ID_W-1:0] w_sel_id;
  logic            w_accept;
  logic [ID_W-1:0] w_sel_plus1;

  // Round-robin search starting at rr_ptr; index wraps by explicit compare so
  // non-power-of-two requester counts never alias onto a missing requester.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = idx[ID_W-1:0];
      end
    end
  end

  // State register: fsm, round-robin pointer and packet owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  // Selection, write-port datapath and next-state decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    grant_id     = '0;
    busy         = 1'b0;

    if (r_state == LOCK) begin
      w_sel_valid = req_valid[r_owner];
      w_sel_id    = r_owner;
      grant_id    = r_owner;
      busy        = 1'b1;
    end else begin
      w_sel_valid = w_found;
      w_sel_id    = w_winner;
      grant_id    = w_found ? w_winner : '0;
    end

    // Full blocks everything, including taking a lock in IDLE.
    w_accept    = w_sel_valid && !fifo_full;
    w_sel_plus1 = (w_sel_id == ID_W'(NUM_REQ - 1)) ? '0 : w_sel_id + 1'b1;

    if (w_accept) begin
      fifo_wr_en          = 1'b1;
      req_ready[w_sel_id] = 1'b1;
      fifo_data_in        = req_data[w_sel_id*DATA_W +: DATA_W];
      if (req_last[w_sel_id]) begin
        w_state_nxt  = IDLE;
        w_rr_ptr_nxt = w_sel_plus1;
      end else begin
        w_state_nxt = LOCK;
        w_owner_nxt = w_sel_id;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt [NUM_REQ];

  // Saturating accepted-beat counters; clear takes priority over a beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr)
          r_cnt[i] <= '0;
        else if (req_ready[i] && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // Flatten counters onto the stats bus.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`endif

endmodule
